// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b, LSB first, one bit per clock (optional ovf output via SERIAL_SUB_OVF_EN)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
`ifdef SERIAL_SUB_OVF_EN
  output logic             done,
  output logic             ovf
`else
  output logic             done
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bout_q, bout_d, d, br_n, last;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  assign d    = a_q[0] ^ b_q[0] ^ br_q;
  assign br_n = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign last = cnt_q == CW'(WIDTH - 1);
  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  // Next state: shift one bit per SHIFT cycle; on the last bit the operands' remaining LSBs are their original MSBs
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      br_d  = br_n;
      res_d = {d, res_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        diff_d  = {d, res_q[WIDTH-1:1]};
        bout_d  = br_n;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = (a_q[0] != b_q[0]) && (d != a_q[0]);
`endif
      end
    end else if (start) begin
      state_d = SHIFT;
      a_d     = a;
      b_d     = b;
      br_d    = 1'b0;
      cnt_d   = '0;
      res_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end
  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against a countdown/arithmetic model
module tb_serial_subtractor;
  localparam int W = 8;
  logic clk = 0, reset = 0, start = 0;
  logic [W-1:0] a = '0, b = '0, diff;
  logic bout, busy, done, ovf;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  int k;
`ifdef SERIAL_SUB_OVF_EN
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .diff(diff), .bout(bout), .busy(busy), .done(done), .ovf(ovf));
`else
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .diff(diff), .bout(bout), .busy(busy), .done(done));
  assign ovf = 1'b0;
`endif
  always #5 clk = ~clk;
  // Behavioural model: an accepted op is busy for W cycles, then done shows the arithmetic result
  int m_left = 0;
  logic m_done = 0, m_bout = 0, m_ovf = 0;
  logic [W-1:0] m_diff = '0, pa = '0, pb = '0, r;
  always @(posedge clk) begin
    if (!reset) begin
      m_left <= 0;
      m_done <= 0;
      m_diff <= '0;
      m_bout <= 0;
      m_ovf  <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        r = pa - pb;
        m_diff <= r;
        m_bout <= pa < pb;
        m_ovf  <= (pa[W-1] != pb[W-1]) && (r[W-1] != pa[W-1]);
      end
    end else begin
      m_done <= 0;
      if (start) begin
        pa <= a;
        pb <= b;
        m_left <= W;
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
`ifdef SERIAL_SUB_OVF_EN
      chk("cycle", {ovf, busy, done, bout, diff}, {m_ovf, m_left > 0, m_done, m_bout, m_diff});
`else
      chk("cycle", {busy, done, bout, diff}, {m_left > 0, m_done, m_bout, m_diff});
`endif
    end
  end
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout waiting for done actual=0 required=1");
    end
  endtask
  task automatic run_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    start = 1; a = x; b = y;
    @(negedge clk);
    start = 0; a = W'($urandom); b = W'($urandom);
    chk({nm, "_busy"}, busy, 1);
    wait_done(n);
    chk({nm, "_latency"}, n, W + 1);
    chk({nm, "_diff"}, diff, ed);
    chk({nm, "_bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, "_ovf"}, ovf, eo);
`endif
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("reset_out", {ovf, busy, done, bout, diff}, '0);
    reset = 1;
    @(negedge clk);
    run_op("s5m3", 8'h05, 8'h03, 8'h02, 0, 0);
    run_op("s3m5", 8'h03, 8'h05, 8'hFE, 1, 0);
    run_op("s80m1", 8'h80, 8'h01, 8'h7F, 0, 1);
    run_op("s0m0", 8'h00, 8'h00, 8'h00, 0, 0);
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 2'b00);
    start = 1; a = 8'd9; b = 8'd4;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    start = 1; a = 8'd1; b = 8'd1;
    @(negedge clk);
    start = 0;
    wait_done(n);
    chk("ignore_start_diff", diff, 8'h05);
    @(negedge clk);
    start = 1; a = 8'h20; b = 8'h08;
    wait_done(n);
    chk("b2b_first_diff", diff, 8'h18);
    a = 8'h10; b = 8'h01;
    @(negedge clk);
    start = 0;
    chk("b2b_busy", busy, 1);
    wait_done(n);
    chk("b2b_latency", n, W + 1);
    chk("b2b_second_diff", diff, 8'h0F);
    @(negedge clk);
    start = 1; a = 8'h55; b = 8'h22;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("abort_out", {busy, done, bout, diff}, '0);
    run_op("after_rst", 8'd7, 8'd2, 8'd5, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom % 250) != 0;
      start = ($urandom % 3) == 0;
      case ($urandom % 4)
        0: a = '0;
        1: a = '1;
        default: a = W'($urandom);
      endcase
      b = ($urandom % 5 == 0) ? a : W'($urandom);
    end
    reset = 1; start = 0;
    repeat (W + 3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, reset; reset is synchronous and active-low.
REQ-004 The module SHALL have port start, input, 1 bit, request to begin a subtraction; sampled only when idle or done.
REQ-005 The module SHALL have port a, input, WIDTH bits, minuend; captured on an accepted start.
REQ-006 The module SHALL have port b, input, WIDTH bits, subtrahend; captured on an accepted start.
REQ-007 The module SHALL have port diff, output, WIDTH bits, result a-b modulo 2^WIDTH.
REQ-008 The module SHALL have port bout, output, 1 bit, final borrow-out: 1 when a<b unsigned.
REQ-009 The module SHALL have port busy, output, 1 bit, high while bits are being processed.
REQ-010 The module SHALL have port done, output, 1 bit, single-cycle pulse marking diff/bout valid.

Function
REQ-011 The module SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 In IDLE or DONE, start=1 SHALL load a and b into shift registers, clear the borrow flop and the bit counter, and enter SHIFT.
REQ-013 In SHIFT, each cycle SHALL compute d = a0 ^ b0 ^ br and br_next = (~a0 & b0) | (~(a0 ^ b0) & br) on the LSBs, shift both operands right, and shift d into the result register MSB.
REQ-014 The bit counter SHALL be sized ceil(log2(WIDTH+1)) bits; SHIFT SHALL last exactly WIDTH cycles, then go to DONE.
REQ-015 Latency: start sampled at edge t SHALL give done=1 in the cycle after edge t+WIDTH (WIDTH+1 edges after acceptance).
REQ-016 done SHALL be high for exactly one cycle on entry to DONE; DONE without start SHALL return to IDLE next cycle.
REQ-017 diff and bout SHALL update only on entry to DONE and hold until the next DONE entry or reset.
REQ-018 busy SHALL equal (state == SHIFT).
REQ-019 start while in SHIFT SHALL be ignored; operands and progress are unaffected.
REQ-020 start asserted in the DONE cycle SHALL be accepted (back-to-back operation, no idle gap).
REQ-021 Changes on a or b after acceptance SHALL NOT affect the result.

Reset
REQ-022 reset=0 at a rising edge SHALL force IDLE, diff=0, bout=0, busy=0, done=0, and clear shift registers, borrow and counter.
REQ-023 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; diff SHALL read 0.
REQ-024 start SHALL be ignored in any cycle where reset=0.

Configuration
REQ-025 Macro SERIAL_SUB_OVF_EN defined SHALL add output ovf, 1 bit, signed two's-complement overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), registered with diff and reset to 0.
REQ-026 Without SERIAL_SUB_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 WIDTH=8, a=5, b=3, start one cycle -> busy for 8 cycles, done pulse 9 edges after acceptance, diff=0x02, bout=0.
REQ-028 a=3, b=5 -> diff=0xFE, bout=1; with SERIAL_SUB_OVF_EN, ovf=0.
REQ-029 a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1 (macro on); a=0, b=0 -> diff=0x00, bout=0.
REQ-030 Start a=9, b=4; pulse start with a=1, b=1 at SHIFT cycle 3 -> ignored, diff=0x05 at done.
REQ-031 Start held high through DONE with new a=0x10, b=0x01 -> second op begins immediately, second done gives diff=0x0F.
REQ-032 reset=0 at SHIFT cycle 4 -> next cycle IDLE, busy=0, diff=0, no done pulse; next start completes normally.
